reverse_arbiter: RTL and testbench
==================================

REVERSE_ARBITER -- requirements
Module: reverse_arbiter

Interface
REQ-001 Parameter N, default 4: word length in digits; each digit is 2 bits, so a word is 2*N bits with digit 0 in the MSB pair.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 offers a word.
REQ-005 req0_word  input  2*N  requester 0 word.
REQ-006 req0_comp  input  1  requester 0 mode: 0 = reverse, 1 = reverse-complement.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle when high together with req0_valid.
REQ-008 req1_valid, req1_word, req1_comp, req1_ready: same widths and meanings as REQ-004..REQ-007, for requester 1.
REQ-009 out_valid  output  1  out_word holds a result.
REQ-010 out_word  output  2*N  registered result.
REQ-011 out_src  output  1  index of the requester that produced out_word.
REQ-012 out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-013 done_cnt  output  16  count of results consumed.

Function
REQ-014 One shared reverse datapath: digit i of the result equals digit N-1-i of the input.
REQ-015 In complement mode, each result digit is replaced by 3 minus the digit (0<->3, 1<->2), applied after reversal.
REQ-016 Output stage: one register. It is "free" in a cycle when out_valid=0 or out_ready=1.
REQ-017 Grant, combinational, evaluated each cycle:
- only one requester valid -> that requester;
- both valid -> the requester not granted last (last_grant register);
- neither valid -> no grant.
REQ-018 reqX_ready = (grant==X) && output stage free; ready never asserts for the non-granted requester.
REQ-019 Accept, i.e. on the edge where reqX_valid && reqX_ready:
- out_word <= transformed reqX_word;
- out_src <= X;
- out_valid <= 1;
- last_grant <= X.
REQ-020 Latency is 1 cycle, input edge to out_valid.
REQ-021 Throughput is one word per cycle when out_ready is held high; accept and drain in the same cycle are permitted.
REQ-022 Drain without a new accept (out_valid && out_ready, no accept): out_valid <= 0; out_word and out_src hold their last values.
REQ-023 Stall (out_valid && !out_ready): out_word, out_src and out_valid hold; both readies are 0.
REQ-024 State machine EMPTY/FULL mirrors out_valid:
- EMPTY->FULL on accept;
- FULL->FULL on stall, or on drain plus accept;
- FULL->EMPTY on drain without accept.
REQ-025 done_cnt increments by 1 on each out_valid && out_ready edge and wraps from 0xFFFF to 0.
REQ-026 Requester inputs are sampled only on the accept edge; changes to a non-accepted word have no effect.
REQ-027 last_grant changes only on accept, never on a lost arbitration or an idle cycle.

Reset
REQ-028 While rst=1 at a rising edge, the following apply on that edge:
- out_valid=0, out_word=0, out_src=0;
- done_cnt=0;
- last_grant=1, so requester 0 wins the first contention;
- state=EMPTY.
REQ-029 rst overrides a simultaneous accept or drain; an in-flight result is discarded and not counted.
REQ-030 During rst=1, req0_ready and req1_ready are 0.

Verification
REQ-031 Basic reverse, N=4: req0 offers 01_00_00_10 with comp=0 and out_ready=1. Required: next cycle out_valid=1, out_word=10_00_00_01, out_src=0, and done_cnt=1 after that edge.
REQ-032 Complement: req1 offers 10_00_01_11 with comp=1. Required: out_word=00_10_11_01, out_src=1.
REQ-033 Contention after reset: both requesters valid continuously with out_ready=1. Required: grants alternate 0,1,0,1, one result per cycle, and each out_src matches its word.
REQ-034 Backpressure: out_ready=0 for 3 cycles with the result 11_01_10_10 reversed = 10_10_01_11 pending. Required: the output holds, both readies are 0, done_cnt is unchanged; after out_ready=1 the drain occurs and done_cnt increments by 1.
REQ-035 Reset mid-operation: rst asserted while out_valid=1 and out_ready=1. Required: out_valid=0, done_cnt=0, and the first contention after reset is granted to req0.
REQ-036 Wrap: done_cnt forced to 0xFFFF via 65535 drains, then one more drain. Required: done_cnt=0.

Source files
------------

// File: rtl/reverse_arbiter_if.sv
// Handshake bundle between two requesters, the shared reverse datapath and its consumer.
// The master side is the requesters plus the consumer; the slave side is the arbiter.
interface reverse_arbiter_if #(
    parameter int N = 4
);
    logic           req0_valid;
    logic [2*N-1:0] req0_word;
    logic           req0_comp;
    logic           req0_ready;
    logic           req1_valid;
    logic [2*N-1:0] req1_word;
    logic           req1_comp;
    logic           req1_ready;
    logic           out_valid;
    logic [2*N-1:0] out_word;
    logic           out_src;
    logic           out_ready;
    logic [15:0]    done_cnt;

    modport master (
        output req0_valid, req0_word, req0_comp,
        input  req0_ready,
        output req1_valid, req1_word, req1_comp,
        input  req1_ready,
        input  out_valid, out_word, out_src, done_cnt,
        output out_ready
    );

    modport slave (
        input  req0_valid, req0_word, req0_comp,
        output req0_ready,
        input  req1_valid, req1_word, req1_comp,
        output req1_ready,
        output out_valid, out_word, out_src, done_cnt,
        input  out_ready
    );
endinterface

// File: rtl/reverse_arbiter.sv
// Two-requester arbiter feeding one digit-reverse / reverse-complement datapath
// with a single registered output stage and a consumed-result counter.
module reverse_arbiter #(
    parameter int N = 4
) (
    input logic              clk,
    input logic              rst,
    reverse_arbiter_if.slave bus
);
    localparam int W = 2 * N;

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t         state;
    state_t         next_state;
    logic           last_grant;
    logic           grant_any;
    logic           grant_idx;
    logic           stage_free;
    logic           accept;
    logic           drain;
    logic [W-1:0]   sel_word;
    logic           sel_comp;
    logic [W-1:0]   out_word_q;
    logic           out_src_q;
    logic [15:0]    done_cnt_q;

    // Digit i of the result takes digit N-1-i; complementing a 2-bit digit is 3-d, i.e. bitwise NOT.
    function automatic logic [W-1:0] transform(input logic [W-1:0] w, input logic comp);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[2*i +: 2] = w[2*(N-1-i) +: 2];
        end
        return comp ? ~r : r;
    endfunction

    always_comb begin
        grant_any = bus.req0_valid || bus.req1_valid;
        grant_idx = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_idx = ~last_grant;
        end else if (bus.req1_valid) begin
            grant_idx = 1'b1;
        end
    end

    always_comb begin
        drain      = (state == FULL) && bus.out_ready;
        stage_free = (state == EMPTY) || bus.out_ready;
        accept     = !rst && grant_any && stage_free;
        sel_word   = grant_idx ? bus.req1_word : bus.req0_word;
        sel_comp   = grant_idx ? bus.req1_comp : bus.req0_comp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (accept) next_state = FULL;
            FULL:    if (drain && !accept) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        bus.out_valid  = (state == FULL);
        bus.req0_ready = accept && (grant_idx == 1'b0);
        bus.req1_ready = accept && (grant_idx == 1'b1);
        bus.out_word   = out_word_q;
        bus.out_src    = out_src_q;
        bus.done_cnt   = done_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_word_q <= '0;
            out_src_q  <= 1'b0;
            last_grant <= 1'b1;
            done_cnt_q <= '0;
        end else begin
            if (accept) begin
                out_word_q <= transform(sel_word, sel_comp);
                out_src_q  <= grant_idx;
                last_grant <= grant_idx;
            end
            if (drain) begin
                done_cnt_q <= done_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_reverse_arbiter.sv
// Directed bench for reverse_arbiter: a per-cycle comparison against a behavioural model
// plus hand-computed literal expectations for the basic, complement, contention, stall, reset and wrap cases.
module tb_reverse_arbiter;
    localparam int N = 4;
    localparam int W = 2 * N;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reverse_arbiter_if #(.N(N)) bus ();

    reverse_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    // Model state: what the output stage must hold, derived from the accept/drain rules.
    logic         m_live;
    logic         m_valid;
    logic [W-1:0] m_word;
    logic         m_src;
    logic [15:0]  m_cnt;
    logic         m_last;

    function automatic logic [W-1:0] m_xform(input logic [W-1:0] w, input logic c);
        int r;
        int d;
        int p;
        r = 0;
        p = 1;
        for (int k = 0; k < N; k++) begin
            d = (int'(w) >> (2 * (N - 1 - k))) & 3;
            if (c) d = 3 - d;
            r = r + d * p;
            p = p * 4;
        end
        return W'(r);
    endfunction

    function automatic int m_winner();
        if (bus.req0_valid && bus.req1_valid) return m_last ? 0 : 1;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic m_free();
        return !m_valid || bus.out_ready;
    endfunction

    initial m_live = 1'b0;

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_word  = '0;
            m_src   = 1'b0;
            m_cnt   = 16'd0;
            m_last  = 1'b1;
        end else if (m_live) begin
            g = m_winner();
            if (m_valid && bus.out_ready) m_cnt = m_cnt + 16'd1;
            if (g >= 0 && m_free()) begin
                m_word  = (g == 0) ? m_xform(bus.req0_word, bus.req0_comp)
                                   : m_xform(bus.req1_word, bus.req1_comp);
                m_src   = (g == 1);
                m_valid = 1'b1;
                m_last  = (g == 1);
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        if (m_live) begin
            g = m_winner();
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("out_word",  32'(bus.out_word),  32'(m_word));
            chk("out_src",   32'(bus.out_src),   32'(m_src));
            chk("done_cnt",  32'(bus.done_cnt),  32'(m_cnt));
            chk("req0_ready", 32'(bus.req0_ready), 32'(!rst && g == 0 && m_free()));
            chk("req1_ready", 32'(bus.req1_ready), 32'(!rst && g == 1 && m_free()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_word = '0; bus.req0_comp = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_word = '0; bus.req1_comp = 1'b0;
        bus.out_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_word",  32'(bus.out_word),  32'd0);
        chk("reset_cnt",   32'(bus.done_cnt),  32'd0);

        // Basic reverse: 01_00_00_10 -> 10_00_00_01
        bus.req0_valid = 1'b1; bus.req0_word = 8'b01_00_00_10; bus.req0_comp = 1'b0;
        bus.out_ready  = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_word",  32'(bus.out_word),  32'b10_00_00_01);
        chk("basic_src",   32'(bus.out_src),   32'd0);
        step();
        chk("basic_cnt",   32'(bus.done_cnt),  32'd1);
        chk("drain_hold",  32'(bus.out_word),  32'b10_00_00_01);

        // Complement: 10_00_01_11 -> reversed 11_01_00_10 -> 00_10_11_01
        bus.req1_valid = 1'b1; bus.req1_word = 8'b10_00_01_11; bus.req1_comp = 1'b1;
        step();
        bus.req1_valid = 1'b0;
        chk("comp_word", 32'(bus.out_word), 32'b00_10_11_01);
        chk("comp_src",  32'(bus.out_src),  32'd1);
        step();

        // Contention after reset: req0 0x1B -> E4, req1 0x00 complemented -> FF
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_word = 8'h1B; bus.req0_comp = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_word = 8'h00; bus.req1_comp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contend_src",  32'(bus.out_src),  32'(i % 2));
            chk("contend_word", 32'(bus.out_word), (i % 2 == 0) ? 32'hE4 : 32'hFF);
            chk("contend_cnt",  32'(bus.done_cnt), 32'(i));
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();

        // Backpressure: 11_01_10_10 -> 10_10_01_11 held for 3 stalled cycles
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_word = 8'b11_01_10_10; bus.req0_comp = 1'b0;
        bus.out_ready  = 1'b0;
        step();
        bus.req0_word  = 8'h55;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_word",  32'(bus.out_word),  32'b10_10_01_11);
            chk("stall_rdy0",  32'(bus.req0_ready), 32'd0);
            chk("stall_rdy1",  32'(bus.req1_ready), 32'd0);
            chk("stall_cnt",   32'(bus.done_cnt),  32'd0);
            step();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b1;
        step();
        chk("release_cnt",   32'(bus.done_cnt),  32'd1);
        chk("release_valid", 32'(bus.out_valid), 32'd0);

        // Reset while a result is draining
        bus.req0_valid = 1'b1; bus.req0_word = 8'h3C; bus.req0_comp = 1'b0;
        step();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_cnt",   32'(bus.done_cnt),  32'd0);
        bus.req1_valid = 1'b1; bus.req1_word = 8'hA5; bus.req1_comp = 1'b0;
        step();
        chk("post_rst_src", 32'(bus.out_src), 32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();

        // Counter wrap: first edge only accepts, every later edge drains one result
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_word = 8'h27; bus.req0_comp = 1'b1;
        bus.out_ready  = 1'b1;
        repeat (65536) step();
        chk("wrap_ffff", 32'(bus.done_cnt), 32'hFFFF);
        step();
        chk("wrap_zero", 32'(bus.done_cnt), 32'd0);
        bus.req0_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
